x_format_exec: RTL and testbench

X_FORMAT_EXEC -- requirements
Module: x_format_exec

---
 rtl/x_format_exec_if.sv | 50 +++++
 rtl/x_format_exec.sv | 201 ++++++++++++++++++++
 tb/tb_x_format_exec.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/x_format_exec_if.sv
// x_format_exec_if -- instruction/result handshake bundle for x_format_exec.
//
// Parameters:
//   XLEN  datapath width in bits
//   NREG  register-file depth; AW = log2(NREG) is the register index width
//
// Signals:
//   in_valid  / in_ready   instruction offered / accepted (transfer when both high at clk edge)
//   instr                  32-bit X-format instruction word
//   res_valid / res_ready  result pending / taken (transfer when both high at clk edge)
//   res_addr               destination register index (RA)
//   res_data               result value
//
// Modports:
//   master  producer of instructions and consumer of results (testbench / upstream)
//   slave   the execution unit
interface x_format_exec_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            res_valid;
    logic            res_ready;
    logic [AW-1:0]   res_addr;
    logic [XLEN-1:0] res_data;

    modport master (
        output in_valid,
        input  in_ready,
        output instr,
        input  res_valid,
        output res_ready,
        input  res_addr,
        input  res_data
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  instr,
        output res_valid,
        input  res_ready,
        output res_addr,
        output res_data
    );
endinterface

// File: rtl/x_format_exec.sv
// x_format_exec -- two-stage executor for PO=31 X-format logical instructions
// (and, nand, or, xor, nor, andc, orc, eqv) over a small register file.
//
// Optional feature macro: X_FORMAT_CR0_EN
//   defined   : cr0 is updated when an instruction with Rc=1 retires
//   undefined : cr0 is tied to 0 and Rc is ignored
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   bus (slave)        instruction in / result out handshakes (x_format_exec_if)
//   illegal            one-cycle pulse after an unsupported instruction is accepted
//   cr0                {LT,GT,EQ,SO} of the last retired Rc=1 result
//   ld_en/addr/data    register preload write port
//   dbg_addr/dbg_data  combinational register-array read (no forwarding)
//
// Handshake rules: a transfer happens on a rising clk edge where valid and
// ready are both high. While res_valid is high and res_ready low, res_addr and
// res_data hold. in_ready depends only on pipeline occupancy and res_ready,
// never on in_valid or ld_en.
module x_format_exec #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    x_format_exec_if.slave  bus,
    output logic            illegal,
    output logic [3:0]      cr0,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_ANDC = 3'd5;
    localparam logic [2:0] OP_ORC  = 3'd6;
    localparam logic [2:0] OP_EQV  = 3'd7;

    logic [XLEN-1:0] regs [NREG];

    // S1: decoded instruction waiting for operands/compute
    logic          s1_valid;
    logic [2:0]    s1_op;
    logic [AW-1:0] s1_ra;
    logic [AW-1:0] s1_rs;
    logic [AW-1:0] s1_rb;
    logic          s1_rc;

    // S2: computed result waiting for the consumer
    logic            res_valid_q;
    logic [AW-1:0]   res_addr_q;
    logic [XLEN-1:0] res_data_q;
    logic            res_rc;

    logic            dec_legal;
    logic [2:0]      dec_op;
    logic            retire;
    logic            s2_free;
    logic            s1_free;
    logic            accept;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rb_val;
    logic [XLEN-1:0] alu_res;

    assign retire  = res_valid_q && bus.res_ready;
    assign s2_free = !res_valid_q || bus.res_ready;
    // S1 can take a new instruction if empty or if it advances this edge.
    assign s1_free = !s1_valid || s2_free;
    assign accept  = bus.in_valid && s1_free;

    assign bus.in_ready  = s1_free;
    assign bus.res_valid = res_valid_q;
    assign bus.res_addr  = res_addr_q;
    assign bus.res_data  = res_data_q;

    assign dbg_data = regs[dbg_addr];

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_AND;
        if (bus.instr[31:26] == 6'd31) begin
            dec_legal = 1'b1;
            case (bus.instr[10:1])
                10'd28:  dec_op = OP_AND;
                10'd476: dec_op = OP_NAND;
                10'd444: dec_op = OP_OR;
                10'd316: dec_op = OP_XOR;
                10'd124: dec_op = OP_NOR;
                10'd60:  dec_op = OP_ANDC;
                10'd412: dec_op = OP_ORC;
                10'd284: dec_op = OP_EQV;
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // Operands are read while the instruction sits in S1. A pending S2 result
    // is newer than the array, so it overrides the array on an index match.
    assign rs_val = (res_valid_q && res_addr_q == s1_rs) ? res_data_q : regs[s1_rs];
    assign rb_val = (res_valid_q && res_addr_q == s1_rb) ? res_data_q : regs[s1_rb];

    always_comb begin
        alu_res = '0;
        case (s1_op)
            OP_AND:  alu_res = rs_val & rb_val;
            OP_NAND: alu_res = ~(rs_val & rb_val);
            OP_OR:   alu_res = rs_val | rb_val;
            OP_XOR:  alu_res = rs_val ^ rb_val;
            OP_NOR:  alu_res = ~(rs_val | rb_val);
            OP_ANDC: alu_res = rs_val & ~rb_val;
            OP_ORC:  alu_res = rs_val | ~rb_val;
            OP_EQV:  alu_res = ~(rs_val ^ rb_val);
            default: alu_res = '0;
        endcase
    end

    // Register array. The retiring write is issued last so it wins over a
    // preload to the same index in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
            if (retire) begin
                regs[res_addr_q] <= res_data_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal     <= 1'b0;
            s1_valid    <= 1'b0;
            s1_op       <= OP_AND;
            s1_ra       <= '0;
            s1_rs       <= '0;
            s1_rb       <= '0;
            s1_rc       <= 1'b0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
            res_rc      <= 1'b0;
        end else begin
            // Unsupported instructions are consumed but never enter S1.
            illegal <= accept && !dec_legal;

            if (s2_free) begin
                res_valid_q <= s1_valid;
                if (s1_valid) begin
                    res_addr_q <= s1_ra;
                    res_data_q <= alu_res;
                    res_rc     <= s1_rc;
                end
            end

            if (s1_free) begin
                s1_valid <= accept && dec_legal;
                if (accept && dec_legal) begin
                    s1_op <= dec_op;
                    s1_ra <= bus.instr[16 +: AW];
                    s1_rs <= bus.instr[21 +: AW];
                    s1_rb <= bus.instr[11 +: AW];
                    s1_rc <= bus.instr[0];
                end
            end
        end
    end

`ifdef X_FORMAT_CR0_EN
    logic [3:0] cr0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr0_q <= 4'b0000;
        end else if (retire && res_rc) begin
            cr0_q <= {res_data_q[XLEN-1],
                      !res_data_q[XLEN-1] && (res_data_q != '0),
                      res_data_q == '0,
                      1'b0};
        end
    end

    assign cr0 = cr0_q;
`else
    logic unused_rc;
    assign unused_rc = res_rc;
    assign cr0       = 4'b0000;
`endif

endmodule

// File: tb/tb_x_format_exec.sv
// tb_x_format_exec -- directed self-checking bench for x_format_exec.
// Expected values are hand-computed constants; cr0 expectations follow
// whether X_FORMAT_CR0_EN is defined for the build.
module tb_x_format_exec;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam int XO_AND  = 28;
    localparam int XO_NAND = 476;
    localparam int XO_OR   = 444;
    localparam int XO_XOR  = 316;
    localparam int XO_NOR  = 124;

`ifdef X_FORMAT_CR0_EN
    localparam logic [3:0] CR0_ZERO = 4'b0010;
    localparam logic [3:0] CR0_NEG  = 4'b1000;
`else
    localparam logic [3:0] CR0_ZERO = 4'b0000;
    localparam logic [3:0] CR0_NEG  = 4'b0000;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            illegal;
    logic [3:0]      cr0;
    logic            ld_en;
    logic [AW-1:0]   ld_addr;
    logic [XLEN-1:0] ld_data;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    x_format_exec_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

    x_format_exec #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .illegal  (illegal),
        .cr0      (cr0),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int po, input int xo, input int ra,
                                       input int rs, input int rb, input bit rc);
        logic [31:0] w;
        w        = '0;
        w[31:26] = po[5:0];
        w[25:21] = rs[4:0];
        w[20:16] = ra[4:0];
        w[15:11] = rb[4:0];
        w[10:1]  = xo[9:0];
        w[0]     = rc;
        return w;
    endfunction

    task automatic preload(input int addr, input logic [XLEN-1:0] data);
        ld_en   = 1'b1;
        ld_addr = addr[AW-1:0];
        ld_data = data;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic check_reg(input string tag, input int addr, input logic [XLEN-1:0] exp);
        dbg_addr = addr[AW-1:0];
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Offer one instruction, wait (bounded) until it is accepted, then drop in_valid.
    task automatic issue(input logic [31:0] w);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.instr    = w;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check("issue_accept", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.res_ready = 1'b1;
        ld_en         = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;
        dbg_addr      = '0;

        // reset
        #2 rst_n = 1'b0;
        #1;
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_cr0", cr0, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check_reg("rst_r7", 7, 64'h0);

        // preload
        preload(12, 64'hF0F0);
        preload(10, 64'hFF00);
        preload(14, 64'hFFFF_FFFF_FFFF_FFFF);
        check_reg("ld_r12", 12, 64'hF0F0);
        check_reg("ld_r10", 10, 64'hFF00);

        // and R7,R12,R10
        issue(mk(31, XO_AND, 7, 12, 10, 1'b0));
        check("and_s1_no_res", bus.res_valid, 1'b0);
        tick();
        check("and_res_valid", bus.res_valid, 1'b1);
        check("and_res_addr", bus.res_addr, 64'd7);
        check("and_res_data", bus.res_data, 64'hF000);
        tick();
        check("and_retired", bus.res_valid, 1'b0);
        check_reg("and_r7", 7, 64'hF000);

        // nand then or to R7
        issue(mk(31, XO_NAND, 7, 12, 10, 1'b0));
        tick();
        check("nand_res_data", bus.res_data, 64'hFFFF_FFFF_FFFF_0FFF);
        issue(mk(31, XO_OR, 7, 12, 10, 1'b0));
        tick();
        check("or_res_data", bus.res_data, 64'hFFF0);
        tick();
        check_reg("or_r7", 7, 64'hFFF0);

        // back-to-back and R7 then xor R8,R7,R10: R7 must come from the pending result
        bus.in_valid = 1'b1;
        bus.instr    = mk(31, XO_AND, 7, 12, 10, 1'b0);
        tick();
        bus.instr    = mk(31, XO_XOR, 8, 7, 10, 1'b0);
        check("b2b_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_first_data", bus.res_data, 64'hF000);
        tick();
        check("b2b_second_valid", bus.res_valid, 1'b1);
        check("b2b_second_addr", bus.res_addr, 64'd8);
        check("b2b_second_data", bus.res_data, 64'h0F00);
        tick();
        check_reg("b2b_r8", 8, 64'h0F00);

        // stall: two instructions queued behind res_ready=0
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = mk(31, XO_XOR, 9, 12, 10, 1'b0);
        tick();
        bus.instr     = mk(31, XO_OR, 11, 12, 10, 1'b0);
        check("stall_second_ready", bus.in_ready, 1'b1);
        tick();
        bus.instr     = mk(31, XO_AND, 12, 12, 10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", bus.in_ready, 1'b0);
            check("stall_res_addr", bus.res_addr, 64'd9);
            check("stall_res_data", bus.res_data, 64'h0FF0);
            check_reg("stall_r9", 9, 64'h0);
            tick();
        end
        bus.in_valid  = 1'b0;
        check_reg("stall_r12_kept", 12, 64'hF0F0);
        bus.res_ready = 1'b1;
        tick();
        check_reg("release_r9", 9, 64'h0FF0);
        check("release_addr", bus.res_addr, 64'd11);
        check("release_data", bus.res_data, 64'hFFF0);
        tick();
        check_reg("release_r11", 11, 64'hFFF0);
        check("release_idle", bus.res_valid, 1'b0);

        // illegal: PO=31 XO=999, then PO=30 with a valid XO
        issue(mk(31, 999, 5, 12, 10, 1'b0));
        check("ill_pulse", illegal, 1'b1);
        check("ill_no_s1", bus.res_valid, 1'b0);
        tick();
        check("ill_pulse_end", illegal, 1'b0);
        check("ill_no_res", bus.res_valid, 1'b0);
        issue(mk(30, XO_AND, 5, 12, 10, 1'b0));
        check("ill_po_pulse", illegal, 1'b1);
        tick();
        check("ill_po_no_res", bus.res_valid, 1'b0);
        check_reg("ill_r5", 5, 64'h0);

        // cr0: nor R13,R14,R14 with Rc=1 gives 0
        issue(mk(31, XO_NOR, 13, 14, 14, 1'b1));
        tick();
        check("nor_data", bus.res_data, 64'h0);
        tick();
        check("cr0_zero", cr0, CR0_ZERO);
        issue(mk(31, XO_NAND, 16, 12, 10, 1'b1));
        tick();
        tick();
        check("cr0_neg", cr0, CR0_NEG);
        issue(mk(31, XO_AND, 17, 12, 10, 1'b0));
        tick();
        tick();
        check("cr0_rc0_hold", cr0, CR0_NEG);

        // preload colliding with a retiring write to the same index
        issue(mk(31, XO_AND, 20, 12, 10, 1'b0));
        tick();
        ld_en   = 1'b1;
        ld_addr = 5'd20;
        ld_data = 64'h1234;
        #1;
        check("ld_in_ready", bus.in_ready, 1'b1);
        tick();
        ld_en = 1'b0;
        check_reg("collide_r20", 20, 64'hF000);

        // reset while a result is pending
        bus.res_ready = 1'b0;
        issue(mk(31, XO_AND, 15, 12, 10, 1'b0));
        tick();
        check("pre_rst_valid", bus.res_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.res_valid, 1'b0);
        check_reg("mid_rst_r15", 15, 64'h0);
        check_reg("mid_rst_r12", 12, 64'h0);
        check("mid_rst_cr0", cr0, 4'b0000);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        check("post_rst_in_ready", bus.in_ready, 1'b1);
        tick();
        check("post_rst_valid", bus.res_valid, 1'b0);
        check_reg("post_rst_r15", 15, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
